fetch_sequencer: RTL and testbench

- Program-counter and fetch-sequencing stage directly upstream of the control decoder.
- Drives the instruction-memory address each cycle.
- Consumes the decoder's jump/call/ret outputs, plus a branch-condition bit from the flag logic, to choose the next PC.
- Owns a small hardware return-address stack for CALL/RET, and the run/halt/fault state of the core.

---
 rtl/fetch_sequencer_if.sv | 44 ++++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer control/status bundle (optional Stall under FETCH_STALL_EN)
interface fetch_sequencer_if #(
   parameter int PCW   = 10,
   parameter int DEPTH = 4
);
   localparam int SPW = $clog2(DEPTH) + 1;

   logic           Start;
   logic [PCW-1:0] StartAddr;
   logic           Jump;
   logic           Call;
   logic           Ret;
   logic           Taken;
   logic [PCW-1:0] Target;
   logic           Halt;
`ifdef FETCH_STALL_EN
   logic           Stall;
`endif
   logic [PCW-1:0] PC;
   logic           Busy;
   logic           Done;
   logic           Fault;
   logic [SPW-1:0] SP;

`ifdef FETCH_STALL_EN
   modport master (
      output Start, StartAddr, Jump, Call, Ret, Taken, Target, Halt, Stall,
      input  PC, Busy, Done, Fault, SP
   );
   modport slave (
      input  Start, StartAddr, Jump, Call, Ret, Taken, Target, Halt, Stall,
      output PC, Busy, Done, Fault, SP
   );
`else
   modport master (
      output Start, StartAddr, Jump, Call, Ret, Taken, Target, Halt,
      input  PC, Busy, Done, Fault, SP
   );
   modport slave (
      input  Start, StartAddr, Jump, Call, Ret, Taken, Target, Halt,
      output PC, Busy, Done, Fault, SP
   );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencing, return-address stack and run/halt/fault control (optional FETCH_STALL_EN)
module fetch_sequencer #(
   parameter int PCW   = 10,
   parameter int DEPTH = 4
) (
   input  logic            Clk,
   input  logic            Reset,
   fetch_sequencer_if.slave bus
);
   localparam int SPW  = $clog2(DEPTH) + 1;
   localparam int IDXW = $clog2(DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
   localparam logic [PCW-1:0] PC_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PCW-1:0]  pc_q, pc_d;
   logic [SPW-1:0]  sp_q, sp_d;
   logic [PCW-1:0]  stack_q [DEPTH];
   logic            push_en;
   logic [IDXW-1:0] push_idx;
   logic [IDXW-1:0] pop_idx;
   logic [PCW-1:0]  pc_inc;
   logic            stall;

`ifdef FETCH_STALL_EN
   assign stall = bus.Stall;
`else
   assign stall = 1'b0;
`endif

   // Push lands at the current top; pop reads the entry just below it.
   assign push_idx = sp_q[IDXW-1:0];
   assign pop_idx  = sp_q[IDXW-1:0] - IDXW'(1);
   assign pc_inc   = pc_q + PCW'(1);

   // Next-state selection: in RUN the inputs are resolved by fixed priority.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      push_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               pc_d    = bus.StartAddr;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!stall) begin
               if (bus.Halt) begin
                  state_d = S_HALTED;
               end else if (bus.Call && bus.Ret) begin
                  state_d = S_FAULT;
               end else if (bus.Ret) begin
                  if (sp_q == '0) begin
                     state_d = S_FAULT;
                  end else begin
                     pc_d = stack_q[pop_idx];
                     sp_d = sp_q - SPW'(1);
                  end
               end else if (bus.Call) begin
                  if (sp_q == SP_FULL) begin
                     state_d = S_FAULT;
                  end else begin
                     push_en = 1'b1;
                     sp_d    = sp_q + SPW'(1);
                     pc_d    = bus.Target;
                  end
               end else if (bus.Jump && bus.Taken) begin
                  pc_d = bus.Target;
               end else if (pc_q == PC_LAST) begin
                  // Running off the top of memory ends the program rather than wrapping.
                  state_d = S_HALTED;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         S_HALTED: begin
            if (bus.Start) begin
               sp_d    = '0;
               pc_d    = bus.StartAddr;
               state_d = S_RUN;
            end
         end
         S_FAULT: begin
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, PC and stack-pointer registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         sp_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
      end
   end

   // Return-address storage; the pushed return address wraps modulo 2^PCW.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else if (push_en) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign bus.PC    = pc_q;
   assign bus.SP    = sp_q;
   assign bus.Busy  = (state_q == S_RUN);
   assign bus.Done  = (state_q == S_HALTED);
   assign bus.Fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with queue-based reference model
module tb_fetch_sequencer;
   localparam int PCW   = 10;
   localparam int DEPTH = 4;
   localparam int PCMAX = (1 << PCW) - 1;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HALTED = 2;
   localparam int M_FAULT  = 3;

   typedef struct {
      int pc;
      int sp;
      int busy;
      int done;
      int fault;
   } exp_t;

   logic Clk;
   logic Reset;

   fetch_sequencer_if #(.PCW(PCW), .DEPTH(DEPTH)) ifc ();

   fetch_sequencer #(.PCW(PCW), .DEPTH(DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifc.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];

   int   m_st  = M_IDLE;
   int   m_pc  = 0;
   int   m_stk[$];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act == expv) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
   endtask

   // Reference behaviour: one clock of the sequencer described with a list-as-stack.
   task automatic model_step(input bit rst, input bit st, input int sa, input bit jmp,
                             input bit cl, input bit rt, input bit tk, input int tg,
                             input bit hl, input bit sl);
      bit eff_stall;
`ifdef FETCH_STALL_EN
      eff_stall = sl;
`else
      eff_stall = 1'b0;
`endif
      if (!rst) begin
         m_st = M_IDLE;
         m_pc = 0;
         m_stk.delete();
         return;
      end
      case (m_st)
         M_IDLE: if (st) begin m_pc = sa; m_st = M_RUN; end
         M_RUN: begin
            if (eff_stall) begin
            end else if (hl) m_st = M_HALTED;
            else if (cl && rt) m_st = M_FAULT;
            else if (rt) begin
               if (m_stk.size() == 0) m_st = M_FAULT;
               else m_pc = m_stk.pop_back();
            end else if (cl) begin
               if (m_stk.size() == DEPTH) m_st = M_FAULT;
               else begin
                  m_stk.push_back((m_pc + 1) % (PCMAX + 1));
                  m_pc = tg;
               end
            end else if (jmp && tk) m_pc = tg;
            else if (m_pc == PCMAX) m_st = M_HALTED;
            else m_pc = m_pc + 1;
         end
         M_HALTED: if (st) begin m_stk.delete(); m_pc = sa; m_st = M_RUN; end
         default: ;
      endcase
   endtask

   task automatic step(input bit rst, input bit st, input int sa, input bit jmp,
                       input bit cl, input bit rt, input bit tk, input int tg,
                       input bit hl, input bit sl);
      exp_t e;
      @(negedge Clk);
      Reset         = rst;
      ifc.Start     = st;
      ifc.StartAddr = PCW'(sa);
      ifc.Jump      = jmp;
      ifc.Call      = cl;
      ifc.Ret       = rt;
      ifc.Taken     = tk;
      ifc.Target    = PCW'(tg);
      ifc.Halt      = hl;
`ifdef FETCH_STALL_EN
      ifc.Stall     = sl;
`endif
      model_step(rst, st, sa, jmp, cl, rt, tk, tg, hl, sl);
      e.pc    = m_pc;
      e.sp    = m_stk.size();
      e.busy  = (m_st == M_RUN);
      e.done  = (m_st == M_HALTED);
      e.fault = (m_st == M_FAULT);
      exp_q.push_back(e);
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
   endtask

   task automatic settle();
      @(posedge Clk);
      #2;
   endtask

   // Monitor: every cycle the DUT presents a new PC/status, compare it with the oldest expectation.
   always @(posedge Clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_pc",    int'(ifc.PC),    e.pc);
         chk("sb_sp",    int'(ifc.SP),    e.sp);
         chk("sb_busy",  int'(ifc.Busy),  e.busy);
         chk("sb_done",  int'(ifc.Done),  e.done);
         chk("sb_fault", int'(ifc.Fault), e.fault);
      end
   end

   initial begin
      bit st, jmp, cl, rt, tk, hl, sl, rst;
      int sa, tg;
      Reset = 1'b0;
      ifc.Start = 0; ifc.StartAddr = '0; ifc.Jump = 0; ifc.Call = 0; ifc.Ret = 0;
      ifc.Taken = 0; ifc.Target = '0; ifc.Halt = 0;
`ifdef FETCH_STALL_EN
      ifc.Stall = 0;
`endif

      do_reset();
      settle();
      chk("reset_pc", int'(ifc.PC), 0);
      chk("reset_busy", int'(ifc.Busy), 0);

      step(1, 1, 'h010, 0, 0, 0, 0, 0, 0, 0);
      settle(); chk("start_pc", int'(ifc.PC), 'h010);
      idle(); idle(); idle();
      settle(); chk("seq_pc", int'(ifc.PC), 'h013);
      chk("seq_busy", int'(ifc.Busy), 1);

      do_reset();
      step(1, 1, 'h020, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 1, 'h100, 0, 0);
      settle(); chk("jump_taken", int'(ifc.PC), 'h100);
      step(1, 0, 0, 1, 0, 0, 0, 'h200, 0, 0);
      settle(); chk("jump_not_taken", int'(ifc.PC), 'h101);

      do_reset();
      step(1, 1, 'h030, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 1, 0, 0, 'h200, 0, 0);
      settle(); chk("call_pc", int'(ifc.PC), 'h200); chk("call_sp", int'(ifc.SP), 1);
      idle(); idle();
      step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      settle(); chk("ret_pc", int'(ifc.PC), 'h031); chk("ret_sp", int'(ifc.SP), 0);

      do_reset();
      step(1, 1, 'h060, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1, 0, 0, 'h100 + 16 * i, 0, 0);
      settle(); chk("ovf_fault", int'(ifc.Fault), 1); chk("ovf_sp", int'(ifc.SP), 4);
      chk("ovf_pc", int'(ifc.PC), 'h130);
      step(1, 1, 'h005, 0, 0, 0, 0, 0, 0, 0);
      settle(); chk("fault_start_ignored", int'(ifc.Fault), 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle(); chk("fault_reset_pc", int'(ifc.PC), 0); chk("fault_reset_fault", int'(ifc.Fault), 0);
      idle();

      step(1, 1, 'h070, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      settle(); chk("udf_fault", int'(ifc.Fault), 1);
      do_reset();
      step(1, 1, 'h070, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 1, 1, 1, 'h123, 0, 0);
      settle(); chk("callret_fault", int'(ifc.Fault), 1); chk("callret_pc", int'(ifc.PC), 'h070);

      do_reset();
      step(1, 1, 'h045, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 1, 0, 1, 'h300, 1, 0);
      settle(); chk("halt_done", int'(ifc.Done), 1); chk("halt_pc", int'(ifc.PC), 'h045);
      step(1, 1, 'h000, 0, 0, 0, 0, 0, 0, 0);
      settle(); chk("restart_pc", int'(ifc.PC), 0); chk("restart_busy", int'(ifc.Busy), 1);
      chk("restart_sp", int'(ifc.SP), 0);

      do_reset();
      step(1, 1, 'h3FF, 0, 0, 0, 0, 0, 0, 0);
      idle();
      settle(); chk("wrap_done", int'(ifc.Done), 1); chk("wrap_pc", int'(ifc.PC), 'h3FF);

`ifdef FETCH_STALL_EN
      do_reset();
      step(1, 1, 'h050, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 1, 'h111, 0, 1);
      step(1, 0, 0, 1, 0, 0, 1, 'h111, 0, 1);
      settle(); chk("stall_pc", int'(ifc.PC), 'h050); chk("stall_busy", int'(ifc.Busy), 1);
      idle();
      settle(); chk("stall_resume", int'(ifc.PC), 'h051);
`endif

      // Randomised run against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst = !((m_st == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 7) == 0);
         sa  = ($urandom_range(0, 3) == 0) ? $urandom_range(PCMAX - 6, PCMAX) : $urandom_range(0, PCMAX);
         jmp = ($urandom_range(0, 3) == 0);
         tk  = $urandom_range(0, 1);
         cl  = ($urandom_range(0, 9) == 0);
         rt  = ($urandom_range(0, 9) == 0);
         hl  = ($urandom_range(0, 39) == 0);
         sl  = ($urandom_range(0, 5) == 0);
         tg  = ($urandom_range(0, 3) == 0) ? $urandom_range(PCMAX - 4, PCMAX) : $urandom_range(0, PCMAX);
         step(rst, st, sa, jmp, cl, rt, tk, tg, hl, sl);
      end

      repeat (4) @(posedge Clk);
      #3;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
